// File: rtl/chn_sched_pkg.sv
// Purpose : shared types and header layout for the channel burst scheduler.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: FSM state encoding, default header tag, header field positions and
//           a helper that assembles a 16-bit burst header word.
package chn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RD   = 2'd2,
    ST_TAIL = 2'd3
  } sched_state_t;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

  // Header layout: TAG [15:12], CHN [11], reserved [10:8] = 0, SEQ [7:0]
  localparam int HDR_TAG_MSB = 15;
  localparam int HDR_TAG_LSB = 12;
  localparam int HDR_CHN_BIT = 11;
  localparam int HDR_SEQ_MSB = 7;

  function automatic logic [15:0] make_hdr(input logic [3:0] tag,
                                           input logic       ch,
                                           input logic [7:0] seq);
    logic [15:0] h;
    h = '0;
    h[HDR_TAG_MSB:HDR_TAG_LSB] = tag;
    h[HDR_CHN_BIT]             = ch;
    h[HDR_SEQ_MSB:0]           = seq;
    return h;
  endfunction

endpackage

// File: rtl/chn_fifo_burst_sched_rr_arb2.sv
// Purpose : 2-requester round-robin arbiter with a registered last-grant pointer.
// Latency : grant is combinational from req; pointer updates on the edge where take is high.
// Backpr. : none; the caller decides when a grant is consumed via take.
// Ports   : clk, reset_n (async, active low), clr (sync pointer reset),
//           req[1:0] (req[0] = chn1, req[1] = chn2), take (grant accepted),
//           gnt_chn (granted channel, valid when |req).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_chn
);

  // Pointer holds the last granted channel; it resets to chn2 so chn1 wins
  // the first tie.
  logic ptr;

  // On a tie, the channel that was not served last wins.
  always_comb begin
    gnt_chn = req[1];
    if (req == 2'b11) gnt_chn = ~ptr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b1;
    end else if (clr) begin
      ptr <= 1'b1;
    end else if (take && |req) begin
      ptr <= gnt_chn;
    end
  end

endmodule

// File: rtl/chn_fifo_burst_sched.sv
// Purpose : round-robin burst scheduler draining chn1/chn2 FIFOs into the USB ext-FIFO
//           write port; each burst is one header word plus BURST_LEN samples.
// Latency : header one cycle after grant; each sample lands on the USB port one cycle
//           after its rdreq.
// Backpr. : almost_full blocks new grants and stalls reads in the same cycle; the
//           (at most one) in-flight word is still written.
// Ports   : clk, reset_n (async, active low), rst_all_fifo (sync flush),
//           chnX_fifo_empty/chnX_usedw/chnX_q in, chnX_rdreq out (X = 1, 2),
//           usb_fifo_almost_full in, out_to_usb_ext_fifo_din/_en out,
//           sched_busy (burst in progress), sched_chn (0 = chn1, 1 = chn2).
module chn_fifo_burst_sched
  import chn_sched_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter int         USEDW_W   = 11,
  parameter int         BURST_LEN = 256,
  parameter logic [3:0] HDR_TAG   = HDR_TAG_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rst_all_fifo,
  input  logic               chn1_fifo_empty,
  input  logic [USEDW_W-1:0] chn1_usedw,
  input  logic [DATA_W-1:0]  chn1_q,
  output logic               chn1_rdreq,
  input  logic               chn2_fifo_empty,
  input  logic [USEDW_W-1:0] chn2_usedw,
  input  logic [DATA_W-1:0]  chn2_q,
  output logic               chn2_rdreq,
  input  logic               usb_fifo_almost_full,
  output logic [DATA_W-1:0]  out_to_usb_ext_fifo_din,
  output logic               out_to_usb_ext_fifo_en,
  output logic               sched_busy,
  output logic               sched_chn
);

  localparam logic [USEDW_W-1:0] BURST_W  = USEDW_W'(BURST_LEN);
  localparam logic [USEDW_W-1:0] LAST_CNT = USEDW_W'(BURST_LEN - 1);

  sched_state_t       state;
  logic [USEDW_W-1:0] cnt;       // reads issued in the current burst
  logic [7:0]         seq1;
  logic [7:0]         seq2;
  logic [DATA_W-1:0]  hdr_q;     // header word held for the HDR cycle
  logic               data_sel;  // 1: din follows the granted FIFO's q
  logic [1:0]         elig;
  logic               take;
  logic               gnt_chn;
  logic               rd_fire;

  assign elig[0] = (chn1_usedw >= BURST_W) && !chn1_fifo_empty;
  assign elig[1] = (chn2_usedw >= BURST_W) && !chn2_fifo_empty;

  assign take = (state == ST_IDLE) && (|elig) && !usb_fifo_almost_full && !rst_all_fifo;

  // A read is issued on every non-stalled RD cycle; cnt never reaches
  // BURST_LEN inside RD because the last read moves the FSM to TAIL.
  assign rd_fire    = (state == ST_RD) && !usb_fifo_almost_full && !rst_all_fifo;
  assign chn1_rdreq = rd_fire && !sched_chn;
  assign chn2_rdreq = rd_fire &&  sched_chn;

  // The channel FIFOs register q on the rdreq edge, so q is already a flop
  // output in the cycle after the read; selecting it here (with a registered
  // select) puts each sample on the port one cycle after its rdreq.
  assign out_to_usb_ext_fifo_din = data_sel ? (sched_chn ? chn2_q : chn1_q) : hdr_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rst_all_fifo),
    .req     (elig),
    .take    (take),
    .gnt_chn (gnt_chn)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= ST_IDLE;
      cnt                    <= '0;
      seq1                   <= '0;
      seq2                   <= '0;
      hdr_q                  <= '0;
      data_sel               <= 1'b0;
      out_to_usb_ext_fifo_en <= 1'b0;
      sched_busy             <= 1'b0;
      sched_chn              <= 1'b0;
    end else if (rst_all_fifo) begin
      // Flush: abort the burst and drop any word still in flight.
      state                  <= ST_IDLE;
      cnt                    <= '0;
      seq1                   <= '0;
      seq2                   <= '0;
      hdr_q                  <= '0;
      data_sel               <= 1'b0;
      out_to_usb_ext_fifo_en <= 1'b0;
      sched_busy             <= 1'b0;
    end else begin
      out_to_usb_ext_fifo_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            sched_chn              <= gnt_chn;
            hdr_q                  <= DATA_W'(make_hdr(HDR_TAG, gnt_chn, gnt_chn ? seq2 : seq1));
            data_sel               <= 1'b0;
            out_to_usb_ext_fifo_en <= 1'b1;
            sched_busy             <= 1'b1;
            state                  <= ST_HDR;
          end
        end
        ST_HDR: begin
          cnt      <= '0;
          data_sel <= 1'b1;
          state    <= ST_RD;
        end
        ST_RD: begin
          if (rd_fire) begin
            out_to_usb_ext_fifo_en <= 1'b1;
            cnt                    <= cnt + 1'b1;
            if (cnt == LAST_CNT) state <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          // The last sample is on the port this cycle via data_sel.
          if (sched_chn) seq2 <= seq2 + 8'd1;
          else           seq1 <= seq1 + 8'd1;
          data_sel   <= 1'b0;
          sched_busy <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
